key_debounce_repeat: RTL

Parametrised debouncer for the keypad scanner path. It takes the raw key_pressed flag and scanned key code and synchronises them. It qualifies a press only when both flag and code stay stable for a programmable interval. It then emits single-cycle press, auto-repeat and release strobes to the display/decoder logic, and sits between the keypad scanner and the digit-capture logic.

---
 rtl/key_debounce_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/key_debounce_repeat.sv | 132 +++++++++++++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the keypad debounce/repeat block.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } kdb_state_t;

    // Defaults for a 48 MHz system clock
    localparam int DEF_DEBOUNCE_CYCLES      = 960000;    // 20 ms
    localparam int DEF_REPEAT_DELAY_CYCLES  = 24000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD_CYCLES = 4800000;   // 100 ms

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; both stages cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_repeat.sv
// Keypad debouncer: qualifies press/release over a stable interval and
// emits single-cycle press, auto-repeat and release strobes.
module key_debounce_repeat
    import key_debounce_pkg::*;
#(
    parameter int CODE_W               = 4,
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN            = 0,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_pressed,
    input  logic [CODE_W-1:0] code_in,
    output logic [CODE_W-1:0] code_out,
    output logic              press_pulse,
    output logic              repeat_pulse,
    output logic              release_pulse,
    output logic              key_held
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                       REPEAT_PERIOD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_DLY  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_PER  = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

    kdb_state_t        state;
    logic              kp_s;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] cand;
    logic [CNT_W-1:0]  db_cnt;
    logic [CNT_W-1:0]  rep_cnt;
    logic              rep_periodic;   // first repeat already issued

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_pressed),
        .q     (kp_s)
    );

    // Code is held stable by the scanner, so a single capture stage suffices
    always_ff @(posedge clk) begin
        if (!reset) code_q <= '0;
        else        code_q <= code_in;
    end

    // Debounce/repeat FSM with registered strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            db_cnt        <= '0;
            rep_cnt       <= '0;
            rep_periodic  <= 1'b0;
            cand          <= '0;
            code_out      <= '0;
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            key_held      <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    db_cnt <= '0;
                    if (kp_s) begin
                        state <= DB_PRESS;
                        cand  <= code_q;
                    end
                end
                DB_PRESS: begin
                    if (!kp_s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (code_q != cand) begin
                        // code moved under us: restart qualification on new code
                        cand   <= code_q;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state        <= HELD;
                        db_cnt       <= '0;
                        code_out     <= cand;
                        press_pulse  <= 1'b1;
                        key_held     <= 1'b1;
                        rep_cnt      <= '0;
                        rep_periodic <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!kp_s) begin
                        state  <= DB_RELEASE;
                        db_cnt <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rep_cnt == (rep_periodic ? RPT_PER : RPT_DLY)) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                            rep_periodic <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
                DB_RELEASE: begin
                    // rep_cnt frozen here so a release bounce resumes the cadence
                    if (kp_s) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        db_cnt        <= '0;
                        release_pulse <= 1'b1;
                        key_held      <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    db_cnt   <= '0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

endmodule
